// File: rtl/coinc_pkg.sv
// Shared constants and channel index tables for the coincidence detector.
// Optional feature macro: COINC_TRIPLE_EN adds the triple-coincidence table.
package coinc_pkg;

  localparam int NUM_CH    = 4;
  localparam int NUM_PAIRS = 6;
  localparam int WIN_W     = 8;

  typedef logic [1:0] ch_idx_t;

  // Pair p covers channels (PAIR_I[p], PAIR_J[p]): AB, AC, AD, BC, BD, CD.
  localparam ch_idx_t PAIR_I [NUM_PAIRS] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
  localparam ch_idx_t PAIR_J [NUM_PAIRS] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3};

`ifdef COINC_TRIPLE_EN
  localparam int NUM_TRIPLES = 4;

  // Triple k is made of the three channels other than k.
  localparam ch_idx_t TRI_A [NUM_TRIPLES] = '{2'd1, 2'd0, 2'd0, 2'd0};
  localparam ch_idx_t TRI_B [NUM_TRIPLES] = '{2'd2, 2'd2, 2'd1, 2'd1};
  localparam ch_idx_t TRI_C [NUM_TRIPLES] = '{2'd3, 2'd3, 2'd3, 2'd2};
`endif

endpackage

// File: rtl/coinc_chan_front.sv
// Per-channel front end: two-flop synchronizer, rising-edge detect and
// coincidence window counter. The window opens the cycle after an edge and
// stays open for WINDOW cycles; a new edge reloads it.
module coinc_chan_front
  import coinc_pkg::*;
#(
  parameter int WINDOW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic edge_det,
  output logic open
);

  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW);

  logic             sync1;
  logic             sync2;
  logic             sync3;
  logic [WIN_W-1:0] win;

  assign edge_det = sync2 & ~sync3;
  assign open     = (win != {WIN_W{1'b0}});

  // Synchronize the asynchronous pulse and track the channel's open window.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      win   <= {WIN_W{1'b0}};
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      sync3 <= sync2;
      if (edge_det) begin
        win <= WIN_LOAD;
      end else if (win != {WIN_W{1'b0}}) begin
        win <= win - {{(WIN_W-1){1'b0}}, 1'b1};
      end else begin
        win <= win;
      end
    end
  end

endmodule

// File: rtl/coinc_detect.sv
// Four-channel coincidence detector: per-channel single-pulse strobes and
// pairwise coincidence strobes, all registered and mutually aligned.
// Optional feature macro: COINC_TRIPLE_EN adds the triple_pulse output.
module coinc_detect
  import coinc_pkg::*;
#(
  parameter int WINDOW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    raw_in,
  output logic [NUM_CH-1:0]    single_pulse,
  output logic [NUM_PAIRS-1:0] coinc_pulse
`ifdef COINC_TRIPLE_EN
  ,
  output logic [NUM_TRIPLES-1:0] triple_pulse
`endif
);

  logic [NUM_CH-1:0]    edge_v;
  logic [NUM_CH-1:0]    open_v;
  logic [NUM_PAIRS-1:0] pair_hit;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
    coinc_chan_front #(
      .WINDOW (WINDOW)
    ) u_front (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw_in[ch]),
      .edge_det (edge_v[ch]),
      .open     (open_v[ch])
    );
  end

  // A pair fires when one member edges while the other edges or is still open.
  always_comb begin
    pair_hit = {NUM_PAIRS{1'b0}};
    for (int p = 0; p < NUM_PAIRS; p++) begin
      pair_hit[p] = (edge_v[PAIR_I[p]] & (edge_v[PAIR_J[p]] | open_v[PAIR_J[p]]))
                  | (edge_v[PAIR_J[p]] & open_v[PAIR_I[p]]);
    end
  end

  // Register single and pair strobes so they leave the block aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      single_pulse <= {NUM_CH{1'b0}};
      coinc_pulse  <= {NUM_PAIRS{1'b0}};
    end else begin
      single_pulse <= edge_v;
      coinc_pulse  <= pair_hit;
    end
  end

`ifdef COINC_TRIPLE_EN
  logic [NUM_TRIPLES-1:0] triple_hit;

  // A triple fires when some member edges and every member is edging or open.
  always_comb begin
    triple_hit = {NUM_TRIPLES{1'b0}};
    for (int k = 0; k < NUM_TRIPLES; k++) begin
      triple_hit[k] = (edge_v[TRI_A[k]] | edge_v[TRI_B[k]] | edge_v[TRI_C[k]])
                    & (edge_v[TRI_A[k]] | open_v[TRI_A[k]])
                    & (edge_v[TRI_B[k]] | open_v[TRI_B[k]])
                    & (edge_v[TRI_C[k]] | open_v[TRI_C[k]]);
    end
  end

  // Register triple strobes in step with the pair strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      triple_pulse <= {NUM_TRIPLES{1'b0}};
    end else begin
      triple_pulse <= triple_hit;
    end
  end
`endif

endmodule
